// File: rtl/grad_mag_threshold.sv
// grad_mag_threshold: L1 gradient magnitude with threshold, border suppression
// and raster sideband markers. Two-stage valid/ready pipeline (S1 abs/capture,
// S2 sum/saturate/compare) with full throughput and stall-safe outputs.
module grad_mag_threshold #(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [2*WIDTH_P-1:0] gx_i,
  input  logic signed [2*WIDTH_P-1:0] gy_i,
  input  logic [WIDTH_P-1:0]        thresh_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [WIDTH_P-1:0]        mag_o,
  output logic                      edge_o,
  output logic                      sof_o,
  output logic                      eol_o
);

  localparam int GW = 2 * WIDTH_P;
  localparam int CW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;

  // Absolute value as unsigned; the most negative code maps to 2^(GW-1) exactly.
  function automatic logic [GW-1:0] abs_f(input logic [GW-1:0] v);
    return v[GW-1] ? (~v + GW'(1)) : v;
  endfunction

  logic          s1_valid_q;
  logic [GW-1:0] ax_q, ay_q;
  logic [WIDTH_P-1:0] th_q;
  logic [CW-1:0] col1_q;
  logic [RW-1:0] row1_q;

  logic               s2_valid_q;
  logic [WIDTH_P-1:0] mag_q;
  logic               edge_q, sof_q, eol_q;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic s2_load, s1_load, accept;

  logic [GW:0]        sum_d;
  logic [WIDTH_P-1:0] mag_sat_d, mag_d;
  logic               border_d, edge_d, sof_d, eol_d;

  assign s2_load = !s2_valid_q | ready_i;
  assign s1_load = !s1_valid_q | s2_load;
  assign accept  = valid_i & s1_load;
  assign ready_o = s1_load;

  // Raster position next-state: advances only on input acceptance.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == CW'(DEPTH_P - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT_P - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // S1: capture magnitudes of both gradients, threshold and beat position.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      ax_q       <= '0;
      ay_q       <= '0;
      th_q       <= '0;
      col1_q     <= '0;
      row1_q     <= '0;
    end else if (s1_load) begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        ax_q   <= abs_f(gx_i);
        ay_q   <= abs_f(gy_i);
        th_q   <= thresh_i;
        col1_q <= col_q;
        row1_q <= row_q;
      end
    end
  end

  // S2 datapath: saturating sum, border suppression, compare and markers.
  always_comb begin
    sum_d     = {1'b0, ax_q} + {1'b0, ay_q};
    mag_sat_d = (|sum_d[GW:WIDTH_P]) ? '1 : sum_d[WIDTH_P-1:0];
    border_d  = (col1_q < CW'(2)) | (row1_q < RW'(2));
    mag_d     = border_d ? '0 : mag_sat_d;
    edge_d    = !border_d & (mag_sat_d >= th_q);
    sof_d     = (col1_q == '0) & (row1_q == '0);
    eol_d     = (col1_q == CW'(DEPTH_P - 1));
  end

  // S2: output register; holds while the downstream stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      mag_q      <= '0;
      edge_q     <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        mag_q  <= mag_d;
        edge_q <= edge_d;
        sof_q  <= sof_d;
        eol_q  <= eol_d;
      end
    end
  end

  assign valid_o = s2_valid_q;
  assign mag_o   = mag_q;
  assign edge_o  = edge_q;
  assign sof_o   = sof_q;
  assign eol_o   = eol_q;

endmodule

// File: doc/grad_mag_threshold.md
Name: grad_mag_threshold

Overview:
- Downstream consumer of the 3x3 window convolution stream; accepts signed gx/gy gradient beats under a valid/ready handshake.
- Computes a saturated L1 magnitude |gx|+|gy| and compares it against a runtime threshold to produce an edge flag.
- Tracks raster position and forces border pixels (window warm-up) to zero.
- Emits sideband start-of-frame and end-of-line markers for the display/writeback stage.

Parameters:
- WIDTH_P, 8, pixel width; gradient inputs are 2*WIDTH_P bits, magnitude output is WIDTH_P bits.
- DEPTH_P, 16, pixels per line; must match the upstream line-buffer depth; must be ≥ 3.
- HEIGHT_P, 16, lines per frame; must be ≥ 3.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; asynchronous assert, active-high.
- valid_i  in  1  upstream beat valid.
- ready_o  out  1  block can accept a beat.
- gx_i  in  2*WIDTH_P  signed horizontal gradient.
- gy_i  in  2*WIDTH_P  signed vertical gradient.
- thresh_i  in  WIDTH_P  edge threshold; sampled with each accepted beat.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream can accept.
- mag_o  out  WIDTH_P  saturated magnitude.
- edge_o  out  1  mag_o ≥ captured threshold.
- sof_o  out  1  beat is pixel (row 0, col 0).
- eol_o  out  1  beat is col DEPTH_P-1.

Behaviour:
- Reset: while rst_i=1, all pipeline registers, valids and counters are 0. valid_o=0, mag_o=0, edge_o=0, sof_o=0, eol_o=0, ready_o=1 once rst_i deasserts. Reset mid-frame discards in-flight beats; the next accepted beat is row 0, col 0.
- Handshake:
  - An input beat is accepted when valid_i & ready_o.
  - An output beat is consumed when valid_o & ready_i.
  - Output fields hold stable while valid_o=1 and ready_i=0.
  - No combinational path from valid_i to valid_o.
- Pipeline: two register stages, S1 and S2, each with its own valid bit.
  - S2 loads when !S2.valid | ready_i.
  - S1 loads when !S1.valid | S2 loads.
  - ready_o = !S1.valid | S2 loads. The only combinational ready path is ready_i → ready_o.
  - Full throughput (1 beat/cycle) when ready_i=1.
  - Latency: a beat accepted at edge N appears on valid_o after edge N+1 and is consumable at edge N+2.
  - Stages never drop or duplicate beats; a stage whose data is consumed in the same cycle it is refilled takes the new data.
- S1 captures:
  - ax = |gx_i| and ay = |gy_i| as unsigned 2*WIDTH_P bits. The most negative input -2^(2W-1) yields 2^(2W-1) exactly, with no wrap.
  - thresh_i.
  - col/row from the position counters.
- S2 computes:
  - sum = ax+ay in 2*WIDTH_P+1 bits.
  - mag = sum > 2^WIDTH_P-1 ? all-ones : sum[WIDTH_P-1:0].
  - If col<2 or row<2, mag=0 and edge=0; otherwise edge = (mag ≥ thresh).
  - sof = (row==0 & col==0); eol = (col==DEPTH_P-1).
- Position counters: col/row advance only on input acceptance.
  - col wraps DEPTH_P-1→0 and increments row.
  - row wraps HEIGHT_P-1→0 at col DEPTH_P-1, starting the next frame.
  - Counters are unaffected by output stalls.
- Simultaneous accept and consume in the same cycle with both stages full: both move; occupancy stays the same.

Test Plan:
- Reset then one beat at row 2 col 2 (after streaming 2*DEPTH_P+2 zero beats): gx=+100, gy=-50, thresh=120, ready_i=1 → two cycles later mag_o=150, edge_o=1, sof_o=0.
- Saturation and extreme values, WIDTH_P=8, interior pixel:
  - gx=-32768, gy=0 → mag_o=255, edge_o=1 for thresh=255.
  - gx=3, gy=-4 → mag_o=7, edge_o=0 for thresh=8.
- Border and sideband: stream a full 16x16 frame of gx=gy=200 →
  - mag_o=0 on rows 0-1 and on cols 0-1 of every row; 255 elsewhere.
  - sof_o exactly on beat 0.
  - eol_o on every 16th beat.
  - 256 output beats, and the second frame's first beat has sof_o=1.
- Backpressure: continuous valid_i with random ready_i (50%) → output sequence identical to the ready_i=1 run; ready_o=0 only when both stages are full and ready_i=0; outputs stable during stalls.
- Reset mid-frame: assert rst_i at beat 37 with both stages full → valid_o drops immediately (asynchronous); the first output after release has sof_o=1 and mag_o=0.
- Bubbles: valid_i toggling 1,0,1,0 with ready_i=1 → each output appears exactly 2 cycles after its acceptance, with no duplicates.
